// File: rtl/ipml_ex_data_packer.sv
// ipml_ex_data_packer: packs RATIO consecutive DATA_W words popped from the ex_data
// prefetch FIFO into one wide beat. One accumulator plus one output register let the
// FIFO drain at full rate while the wide output is back-pressured.
// Optional feature macro: EX_DATA_PACK_FLUSH_EN (idle-timeout flush of partial beats).
module ipml_ex_data_packer #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned FLUSH_CYC = 16,
   localparam int unsigned CNT_W    = $clog2(RATIO) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_vld,
   output logic                      in_rdy,
   output logic [DATA_W*RATIO-1:0]   out_data,
   output logic [RATIO-1:0]          out_keep,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [CNT_W-1:0]          fill_cnt
);

   localparam int unsigned OUT_W = DATA_W * RATIO;

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e             state_q, state_d;
   logic               rdy_en_q, rdy_en_d;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic [RATIO-1:0]   out_keep_q, out_keep_d;
   logic               out_vld_q, out_vld_d;

   logic               accept;
   logic               slot_free;
   logic               last_word;
   logic               flush_fire;
   logic               load_out;
   logic [OUT_W-1:0]   acc_wr;
   logic [CNT_W-1:0]   fill_wr;
   logic [RATIO-1:0]   keep_mask;

`ifdef EX_DATA_PACK_FLUSH_EN
   logic [7:0]         idle_cnt_q, idle_cnt_d;

   // Idle timer: counts FILL cycles holding words with no accept; fires on the
   // FLUSH_CYC-th such cycle. An accept in that cycle wins and clears it.
   always_comb begin
      flush_fire = (state_q == StFill) && !accept && (fill_cnt_q != '0) &&
                   (idle_cnt_q == 8'(FLUSH_CYC - 1));
      if ((state_q != StFill) || accept || (fill_cnt_q == '0) || flush_fire) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + 8'd1;
      end
   end

   // Idle timer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   // FLUSH_CYC has no effect without the flush feature.
   logic unused_flush_cyc;
   assign unused_flush_cyc = ^FLUSH_CYC;
   assign flush_fire = 1'b0;
`endif

   // Handshake qualifiers and accumulator write of the incoming word
   always_comb begin
      accept    = in_vld & in_rdy;
      slot_free = ~out_vld_q | out_rdy;
      last_word = accept && (fill_cnt_q == CNT_W'(RATIO - 1));
      fill_wr   = fill_cnt_q + CNT_W'(accept);
      acc_wr    = acc_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (accept && (fill_cnt_q == CNT_W'(i))) begin
            acc_wr[i*DATA_W +: DATA_W] = in_data;
         end
      end
      // Lanes holding words; all ones for a full beat, lower bits for a flush.
      for (int unsigned i = 0; i < RATIO; i++) begin
         keep_mask[i] = (CNT_W'(i) < fill_wr);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFill;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: park in HOLD when a beat is complete but the output slot is busy
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill: if ((last_word || flush_fire) && !slot_free) state_d = StHold;
         StHold: if (slot_free) state_d = StFill;
         default: state_d = StFill;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_rdy = (state_q == StFill) && rdy_en_q;
   end

   // Datapath next state: accumulate, hand the beat to the output register, retire beats
   always_comb begin
      rdy_en_d   = 1'b1;
      acc_d      = acc_wr;
      fill_cnt_d = fill_wr;
      out_data_d = out_data_q;
      out_keep_d = out_keep_q;
      out_vld_d  = out_vld_q;
      load_out   = slot_free && ((state_q == StHold) || last_word || flush_fire);
      if (load_out) begin
         out_data_d = acc_wr;
         out_keep_d = keep_mask;
         out_vld_d  = 1'b1;
         // Clearing keeps unused lanes of the next (possibly partial) beat at zero.
         acc_d      = '0;
         fill_cnt_d = '0;
      end else if (out_vld_q && out_rdy) begin
         out_vld_d  = 1'b0;
      end
   end

   // Datapath registers; reset discards any partially packed beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q   <= 1'b0;
         acc_q      <= '0;
         fill_cnt_q <= '0;
         out_data_q <= '0;
         out_keep_q <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         rdy_en_q   <= rdy_en_d;
         acc_q      <= acc_d;
         fill_cnt_q <= fill_cnt_d;
         out_data_q <= out_data_d;
         out_keep_q <= out_keep_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign out_data = out_data_q;
   assign out_keep = out_keep_q;
   assign out_vld  = out_vld_q;
   assign fill_cnt = fill_cnt_q;

endmodule

// File: tb/tb_ipml_ex_data_packer.sv
// Bench for ipml_ex_data_packer: directed phases plus random traffic, every cycle
// compared against a queue-based model of the packing rules.
module tb_ipml_ex_data_packer;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned RATIO     = 4;
   localparam int unsigned FLUSH_CYC = 16;
   localparam int unsigned CNT_W     = $clog2(RATIO) + 1;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [DATA_W-1:0]       in_data;
   logic                    in_vld;
   logic                    in_rdy;
   logic [DATA_W*RATIO-1:0] out_data;
   logic [RATIO-1:0]        out_keep;
   logic                    out_vld;
   logic                    out_rdy;
   logic [CNT_W-1:0]        fill_cnt;

   always #5 clk = ~clk;

   ipml_ex_data_packer #(
      .DATA_W   (DATA_W),
      .RATIO    (RATIO),
      .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_data (in_data),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .out_data(out_data),
      .out_keep(out_keep),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .fill_cnt(fill_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Model: words accepted but not yet in a beat, plus the expected output register.
   logic [DATA_W-1:0]       pend[$];
   bit                      m_vld;
   logic [DATA_W*RATIO-1:0] m_data;
   logic [RATIO-1:0]        m_keep;
   bit                      m_rdy_en;
   bit                      m_hold;
   int                      m_idle;
   int                      partial_beats;
   logic [DATA_W-1:0]       cur_word;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_rdy();
      return m_rdy_en && (pend.size() < RATIO) && !m_hold;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".in_rdy"},   in_rdy,   exp_rdy());
      chk({tag, ".out_vld"},  out_vld,  m_vld);
      chk({tag, ".out_data"}, out_data, m_data);
      chk({tag, ".out_keep"}, out_keep, m_keep);
      chk({tag, ".fill_cnt"}, fill_cnt, pend.size());
   endtask

   task automatic model_reset();
      pend.delete();
      m_vld    = 0;
      m_data   = '0;
      m_keep   = '0;
      m_rdy_en = 0;
      m_hold   = 0;
      m_idle   = 0;
   endtask

   // Predict the effect of the coming clock edge.
   task automatic model_edge(input bit vld, input logic [DATA_W-1:0] d, input bit ordy);
      bit acc;
      bit slot;
      bit hs;
      int n;
      acc  = vld && exp_rdy();
      slot = !m_vld || ordy;
      hs   = m_vld && ordy;
`ifdef EX_DATA_PACK_FLUSH_EN
      if (m_hold || pend.size() == RATIO || acc || pend.size() == 0) begin
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == FLUSH_CYC) begin
            m_hold = 1;
            m_idle = 0;
         end
      end
`endif
      if (acc) pend.push_back(d);
      if ((pend.size() == RATIO || m_hold) && slot) begin
         n      = pend.size();
         m_data = '0;
         m_keep = '0;
         for (int i = 0; i < n; i++) begin
            m_data[i*DATA_W +: DATA_W] = pend.pop_front();
            m_keep[i] = 1'b1;
         end
         m_vld  = 1;
         m_hold = 0;
         if (n < RATIO) partial_beats++;
      end else if (hs) begin
         m_vld = 0;
      end
      m_rdy_en = 1;
   endtask

   // One cycle: check outputs, drive inputs for the next edge, advance the model.
   task automatic step(input bit vld, input bit ordy);
      bit a;
      @(negedge clk);
      check_outputs("step");
      in_vld  = vld;
      in_data = cur_word;
      out_rdy = ordy;
      a = vld && exp_rdy();
      model_edge(vld, cur_word, ordy);
      if (a) cur_word = $urandom;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n   = 1'b0;
      in_vld  = 1'b1;
      out_rdy = 1'b0;
      model_reset();
      #1;
      check_outputs("reset_assert");
      repeat (n) begin
         @(negedge clk);
         check_outputs("reset_hold");
      end
      rst_n = 1'b1;
      check_outputs("reset_release");
      model_edge(1'b1, cur_word, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b1;
      in_vld        = 1'b0;
      in_data       = '0;
      out_rdy       = 1'b0;
      partial_beats = 0;
      cur_word      = '0;
      model_reset();

      // Reset with in_vld held high
      do_reset(5);

      // Streaming 0x1..0x8 with out_rdy high
      for (int k = 1; k <= 8; k++) begin
         cur_word = DATA_W'(k);
         step(1'b1, 1'b1);
         if (k == 5) chk("stream_beat0", out_data, 128'h00000004_00000003_00000002_00000001);
      end
      step(1'b0, 1'b1);
      chk("stream_beat1", out_data, 128'h00000008_00000007_00000006_00000005);
      chk("stream_keep", out_keep, 4'hF);
      repeat (3) step(1'b0, 1'b1);

      // Back-pressure: eight words against a stalled output
      cur_word = $urandom;
      repeat (12) step(1'b1, 1'b0);
      chk("bp_fill", fill_cnt, 4);
      chk("bp_in_rdy", in_rdy, 1'b0);
      chk("bp_out_vld", out_vld, 1'b1);
      repeat (8) step(1'b0, 1'b1);

      // Same-edge handoff: a beat retires on the edge the next one completes
      repeat (7) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      chk("handoff_vld", out_vld, 1'b1);
      chk("handoff_fill", fill_cnt, 0);
      repeat (3) step(1'b0, 1'b1);

`ifdef EX_DATA_PACK_FLUSH_EN
      // Idle flush of three words
      repeat (3) step(1'b1, 1'b1);
      repeat (16) step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("flush_keep", out_keep, 4'b0111);
      chk("flush_lane3", out_data[127:96], 32'h0);
      repeat (2) step(1'b0, 1'b1);
      // A word in the 16th idle cycle suppresses the flush
      repeat (3) step(1'b1, 1'b1);
      repeat (15) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("noflush_keep", out_keep, 4'hF);
      chk("noflush_vld", out_vld, 1'b1);
      chk("flush_count", partial_beats, 1);
      repeat (2) step(1'b0, 1'b1);
`endif

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      end
      repeat (6) step(1'b0, 1'b1);

      // Reset mid-beat: two accepted words are discarded
      do_reset(1);
      repeat (2) step(1'b1, 1'b1);
      do_reset(2);
      chk("rst_mid_fill", fill_cnt, 0);
      repeat (20) step(1'b0, 1'b1);
      chk("rst_mid_out_vld", out_vld, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
